sm_arbiter: RTL
===============

Name: sm_arbiter

Overview:
- Shares one single-port shared-memory macro between N GPU cores.
- Each core issues at most one outstanding load or store using its `mem_req_ld`/`mem_req_st` hold-until-`val_data` handshake.
- The arbiter grants cores round-robin, sequences the memory access (fixed read latency), and returns a one-cycle `val_data` pulse and read data to the granted core.
- It sits between the core array and the shared-memory macro, in place of the per-core direct connection.

Parameters:
- N_CORES, 4, number of requesting cores; legal range 1..16.
- AW, 12, shared-memory address width.
- DW, 8, data width.
- RD_LAT, 1, memory read latency: cycles from the `sm_re` cycle to the `sm_rdata`-valid cycle; legal range 1..4.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- mem_req_ld  in  N_CORES  per-core load request; held until that core's `val_data`
- mem_req_st  in  N_CORES  per-core store request; held until that core's `val_data`
- core_addr  in  N_CORES*AW  packed per-core address; core k occupies bits [k*AW +: AW]; valid while the core's request is high
- core_wdata  in  N_CORES*DW  packed per-core store data; core k occupies bits [k*DW +: DW]
- val_data  out  N_CORES  one-hot completion pulse, one cycle wide
- mem_dat  out  DW  load-return data, broadcast to all cores; valid in the `val_data` cycle
- sm_addr  out  AW  memory address
- sm_re  out  1  memory read strobe
- sm_we  out  1  memory write strobe
- sm_wdata  out  DW  memory write data
- sm_rdata  in  DW  memory read data
- busy  out  1  high whenever the FSM is not in IDLE
- grant_id  out  4  index of the granted core; holds its last value when idle

Behaviour:
- All outputs are registered.
- Reset values:
  - `val_data`, `sm_re`, `sm_we`, `busy` = 0.
  - `sm_addr`, `sm_wdata`, `mem_dat`, `grant_id` = 0.
  - State = IDLE.
  - Round-robin pointer `last` = N_CORES-1, so core 0 has first priority.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - `req[k] = mem_req_ld[k] | mem_req_st[k]`.
  - If any bit is set, select the first set k searching `last+1, last+2, …` modulo N_CORES.
  - Latch k, the operation type (load if `mem_req_ld[k]`, else store), `core_addr[k]` into `sm_addr`, and `core_wdata[k]` into `sm_wdata`.
  - Set `grant_id = k`, `last = k`, go to ISSUE.
- ISSUE (one cycle): `sm_re = 1` for a load, `sm_we = 1` for a store.
  - Store → RESP.
  - Load → WAIT.
- WAIT:
  - Counts RD_LAT-1 further cycles.
  - In the cycle where `sm_rdata` is valid (RD_LAT cycles after the ISSUE cycle), register it into `mem_dat` and go to RESP.
  - With RD_LAT=1, WAIT lasts exactly one cycle.
- RESP (one cycle): `val_data[grant] = 1`, then → IDLE. `mem_dat` holds its value until the next load capture; stores do not alter it.
- Latency, from the first cycle a request is sampled in IDLE to the `val_data` cycle:
  - Store: 2 cycles.
  - Load: 2+RD_LAT cycles.
- Back-to-back transactions: the granted core drops its request at the edge ending RESP, so it is never re-granted from a stale request.
- Minimum spacing between grants is one IDLE cycle.
- Boundary cases:
  - `mem_req_ld` and `mem_req_st` both high on the same core: illegal; treated as a load.
  - A request dropped after grant: the transaction still completes and pulses `val_data`.
  - A new request arriving during a transaction waits; it is not lost.
  - Only one core requesting: granted immediately, regardless of `last`.
  - Pointer wrap: after granting core N_CORES-1, the search starts at core 0.
  - Reset in any state: next cycle is IDLE with reset values. Any in-flight strobe or `val_data` is cancelled.
  - `busy = (state != IDLE)`.

Optional Feature:
- Macro: SM_ARBITER_PERF_EN.
- When defined, add outputs:
  - `perf_ld_cnt[15:0]`: completed loads.
  - `perf_st_cnt[15:0]`: completed stores.
  - `perf_stall_cnt[15:0]`: cycles in which at least one request bit is set for a core that is not currently granted.
- All three counters saturate at 16'hFFFF and reset to 0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single store: core 2 st, addr 12'h0A5, data 8'h3C.
  - Expect `sm_we` one cycle later with addr 0A5 / data 3C.
  - Expect `val_data` = 4'b0100 two cycles after the request.
- Single load, RD_LAT=1: core 0 ld, addr 12'h0A5, memory returns 8'h3C.
  - Expect `sm_re` at +1, `val_data` = 4'b0001 at +3, `mem_dat` = 8'h3C.
- Round-robin: all 4 cores request stores at once, each re-requesting immediately after its `val_data`.
  - Expect grant order 0,1,2,3,0 with one IDLE cycle between grants.
- Mixed contention: core 3 ld and core 1 st both pending with `last`=1.
  - Expect core 3 served first, then core 1.
  - `mem_dat` unchanged by core 1's store.
- Reset mid-load: assert reset during WAIT.
  - Expect no `val_data`; all outputs 0 next cycle.
  - A subsequent core 1 request is granted normally.
- SM_ARBITER_PERF_EN: 3 loads and 2 stores with overlap.
  - Expect `perf_ld_cnt` = 3, `perf_st_cnt` = 2.
  - `perf_stall_cnt` equals the counted overlap cycles.

Source files
------------

// File: rtl/sm_arbiter.sv
// Round-robin arbiter sharing one single-port shared-memory macro among N_CORES cores.
// Defining SM_ARBITER_PERF_EN adds saturating load/store/stall performance counters.
module sm_arbiter #(
  parameter int N_CORES = 4,
  parameter int AW      = 12,
  parameter int DW      = 8,
  parameter int RD_LAT  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CORES-1:0]    mem_req_ld,
  input  logic [N_CORES-1:0]    mem_req_st,
  input  logic [N_CORES*AW-1:0] core_addr,
  input  logic [N_CORES*DW-1:0] core_wdata,
  output logic [N_CORES-1:0]    val_data,
  output logic [DW-1:0]         mem_dat,
  output logic [AW-1:0]         sm_addr,
  output logic                  sm_re,
  output logic                  sm_we,
  output logic [DW-1:0]         sm_wdata,
  input  logic [DW-1:0]         sm_rdata,
  output logic                  busy,
  output logic [3:0]            grant_id
`ifdef SM_ARBITER_PERF_EN
  ,
  output logic [15:0]           perf_ld_cnt,
  output logic [15:0]           perf_st_cnt,
  output logic [15:0]           perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [3:0]           last_r, last_nxt_s;
  logic [3:0]           grant_r, grant_nxt_s;
  logic                 is_ld_r, is_ld_nxt_s;
  logic [1:0]           cnt_r, cnt_nxt_s;
  logic [AW-1:0]        sm_addr_r, sm_addr_nxt_s;
  logic [DW-1:0]        sm_wdata_r, sm_wdata_nxt_s;
  logic [DW-1:0]        mem_dat_r, mem_dat_nxt_s;
  logic                 sm_re_r, sm_re_nxt_s;
  logic                 sm_we_r, sm_we_nxt_s;
  logic [N_CORES-1:0]   val_data_r, val_data_nxt_s;
  logic                 busy_r;

  logic [N_CORES-1:0]   req_s;
  logic [15:0]          req_pad_s;
  logic                 found_s;
  logic [3:0]           pick_s;
  logic                 sel_ld_s;
  logic [AW-1:0]        sel_addr_s;
  logic [DW-1:0]        sel_wdata_s;

  function automatic logic [N_CORES-1:0] onehot(input logic [3:0] idx);
    logic [N_CORES-1:0] v;
    for (int k = 0; k < N_CORES; k++) begin
      v[k] = (idx == 4'(k));
    end
    return v;
  endfunction

  assign req_s     = mem_req_ld | mem_req_st;
  assign req_pad_s = 16'(req_s);

  // Round-robin search starting just after the last granted core, wrapping modulo N_CORES.
  always_comb begin
    logic [4:0] sum_s;
    logic [4:0] cand_s;
    logic       hit_s;
    found_s = 1'b0;
    pick_s  = last_r;
    sum_s   = 5'd0;
    cand_s  = 5'd0;
    hit_s   = 1'b0;
    for (int i = 1; i <= N_CORES; i++) begin
      sum_s   = {1'b0, last_r} + 5'(i);
      cand_s  = (sum_s >= 5'(N_CORES)) ? (sum_s - 5'(N_CORES)) : sum_s;
      hit_s   = ~found_s & req_pad_s[cand_s[3:0]];
      pick_s  = hit_s ? cand_s[3:0] : pick_s;
      found_s = found_s | hit_s;
    end
  end

  // Mux the picked core's operation type, address and write data.
  always_comb begin
    sel_ld_s    = 1'b0;
    sel_addr_s  = {AW{1'b0}};
    sel_wdata_s = {DW{1'b0}};
    for (int k = 0; k < N_CORES; k++) begin
      sel_ld_s    = (pick_s == 4'(k)) ? mem_req_ld[k]            : sel_ld_s;
      sel_addr_s  = (pick_s == 4'(k)) ? core_addr[k*AW +: AW]    : sel_addr_s;
      sel_wdata_s = (pick_s == 4'(k)) ? core_wdata[k*DW +: DW]   : sel_wdata_s;
    end
  end

  // Next-state and next-output logic; strobes and completion pulses default low.
  always_comb begin
    state_nxt_s    = state_r;
    last_nxt_s     = last_r;
    grant_nxt_s    = grant_r;
    is_ld_nxt_s    = is_ld_r;
    cnt_nxt_s      = cnt_r;
    sm_addr_nxt_s  = sm_addr_r;
    sm_wdata_nxt_s = sm_wdata_r;
    mem_dat_nxt_s  = mem_dat_r;
    sm_re_nxt_s    = 1'b0;
    sm_we_nxt_s    = 1'b0;
    val_data_nxt_s = {N_CORES{1'b0}};
    case (state_r)
      IDLE: begin
        if (found_s) begin
          // A core with both requests set is treated as a load.
          grant_nxt_s    = pick_s;
          last_nxt_s     = pick_s;
          is_ld_nxt_s    = sel_ld_s;
          sm_addr_nxt_s  = sel_addr_s;
          sm_wdata_nxt_s = sel_wdata_s;
          sm_re_nxt_s    = sel_ld_s;
          sm_we_nxt_s    = ~sel_ld_s;
          state_nxt_s    = ISSUE;
        end else begin
          state_nxt_s    = IDLE;
        end
      end
      ISSUE: begin
        if (is_ld_r) begin
          cnt_nxt_s      = 2'd0;
          state_nxt_s    = WAIT;
        end else begin
          val_data_nxt_s = onehot(grant_r);
          state_nxt_s    = RESP;
        end
      end
      WAIT: begin
        if (cnt_r == 2'(RD_LAT - 1)) begin
          mem_dat_nxt_s  = sm_rdata;
          val_data_nxt_s = onehot(grant_r);
          state_nxt_s    = RESP;
        end else begin
          cnt_nxt_s      = cnt_r + 2'd1;
          state_nxt_s    = WAIT;
        end
      end
      RESP: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      last_r     <= 4'(N_CORES - 1);
      grant_r    <= 4'd0;
      is_ld_r    <= 1'b0;
      cnt_r      <= 2'd0;
      sm_addr_r  <= {AW{1'b0}};
      sm_wdata_r <= {DW{1'b0}};
      mem_dat_r  <= {DW{1'b0}};
      sm_re_r    <= 1'b0;
      sm_we_r    <= 1'b0;
      val_data_r <= {N_CORES{1'b0}};
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      last_r     <= last_nxt_s;
      grant_r    <= grant_nxt_s;
      is_ld_r    <= is_ld_nxt_s;
      cnt_r      <= cnt_nxt_s;
      sm_addr_r  <= sm_addr_nxt_s;
      sm_wdata_r <= sm_wdata_nxt_s;
      mem_dat_r  <= mem_dat_nxt_s;
      sm_re_r    <= sm_re_nxt_s;
      sm_we_r    <= sm_we_nxt_s;
      val_data_r <= val_data_nxt_s;
      busy_r     <= (state_nxt_s != IDLE);
    end
  end

  assign val_data = val_data_r;
  assign mem_dat  = mem_dat_r;
  assign sm_addr  = sm_addr_r;
  assign sm_re    = sm_re_r;
  assign sm_we    = sm_we_r;
  assign sm_wdata = sm_wdata_r;
  assign busy     = busy_r;
  assign grant_id = grant_r;

`ifdef SM_ARBITER_PERF_EN
  logic [N_CORES-1:0] active_s;
  logic               stall_s;
  logic [15:0]        ld_cnt_r, st_cnt_r, stall_cnt_r;

  // In IDLE the core picked this cycle counts as granted; otherwise the latched grant does.
  assign active_s = (state_r == IDLE) ? (found_s ? onehot(pick_s) : {N_CORES{1'b0}})
                                      : onehot(grant_r);
  assign stall_s  = |(req_s & ~active_s);

  // Saturating completion and stall counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_cnt_r    <= 16'd0;
      st_cnt_r    <= 16'd0;
      stall_cnt_r <= 16'd0;
    end else begin
      if ((state_r == RESP) && is_ld_r && (ld_cnt_r != 16'hFFFF)) begin
        ld_cnt_r <= ld_cnt_r + 16'd1;
      end else begin
        ld_cnt_r <= ld_cnt_r;
      end
      if ((state_r == RESP) && !is_ld_r && (st_cnt_r != 16'hFFFF)) begin
        st_cnt_r <= st_cnt_r + 16'd1;
      end else begin
        st_cnt_r <= st_cnt_r;
      end
      if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign perf_ld_cnt    = ld_cnt_r;
  assign perf_st_cnt    = st_cnt_r;
  assign perf_stall_cnt = stall_cnt_r;
`endif

endmodule
